// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end for one shared combinational ALU.
// One operation is in flight at a time: IDLE (accept) -> EXEC (capture ALU) -> RESP (hold
// the result until the owning port takes it).
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    // request port 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    // request port 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    // response port 0
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic [2:0]       rsp0_flags,
    // response port 1
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,
    output logic [2:0]       rsp1_flags,
    // shared ALU
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_carry,
    input  logic             alu_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             prio;       // port that wins when both request
    logic             owner_p0;   // port that owns the operation in flight
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [OPW-1:0]   op_p0;
    logic [WIDTH-1:0] y_p1;
    logic [2:0]       flags_p1;   // {err, carry, ovf}
    logic             accept0;
    logic             accept1;
    logic             rsp_hs;

    // Opcodes 0-5 and 7-10 are implemented by the ALU; everything else reports err.
    function automatic logic op_legal(input logic [OPW-1:0] op);
        return (op != OPW'(6)) && (op <= OPW'(10));
    endfunction

    // Grant only while idle; the prio port wins a tie, a lone requester always wins.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && !rst) begin
            req0_ready = req0_valid && (!prio || !req1_valid);
            req1_ready = req1_valid && ( prio || !req0_valid);
        end
    end

    assign accept0 = req0_valid && req0_ready;
    assign accept1 = req1_valid && req1_ready;
    assign rsp_hs  = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign alu_a      = a_p0;
    assign alu_b      = b_p0;
    assign alu_op     = op_p0;
    assign rsp0_y     = y_p1;
    assign rsp1_y     = y_p1;
    assign rsp0_flags = flags_p1;
    assign rsp1_flags = flags_p1;

    // Control FSM with registered operands, result and response/busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner_p0   <= 1'b0;
            a_p0       <= '0;
            b_p0       <= '0;
            op_p0      <= '0;
            y_p1       <= '0;
            flags_p1   <= 3'b000;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // request capture: operands stay on the ALU until the response is taken
                    if (accept0 || accept1) begin
                        state    <= EXEC;
                        busy     <= 1'b1;
                        owner_p0 <= accept1;
                        a_p0     <= accept1 ? req1_a  : req0_a;
                        b_p0     <= accept1 ? req1_b  : req0_b;
                        op_p0    <= accept1 ? req1_op : req0_op;
                        prio     <= ~accept1;
                    end
                end
                EXEC: begin
                    // result capture: the ALU has had a full cycle on stable operands
                    state <= RESP;
                    if (op_legal(op_p0)) begin
                        y_p1     <= alu_y;
                        flags_p1 <= {1'b0, alu_carry, alu_ovf};
                    end else begin
                        y_p1     <= '0;
                        flags_p1 <= 3'b100;
                    end
                    rsp0_valid <= ~owner_p0;
                    rsp1_valid <= owner_p0;
                end
                RESP: begin
                    // response handoff: result registers keep their value after the handshake
                    if (rsp_hs) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic for alu_arbiter.
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int OPW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]   req0_op, req1_op;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp0_y, rsp1_y;
    logic [2:0]       rsp0_flags, rsp1_flags;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [OPW-1:0]   alu_op;
    logic             alu_carry, alu_ovf, busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y), .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .busy(busy)
    );

    // Shared ALU: bit-level model; unimplemented opcodes produce junk that must be ignored.
    always_comb begin
        logic [WIDTH:0] s;
        s         = '0;
        alu_y     = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_op)
            5'd0: begin
                s = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y = s[WIDTH-1:0]; alu_carry = s[WIDTH];
                alu_ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (s[WIDTH-1] != alu_a[WIDTH-1]);
            end
            5'd1: begin
                s = {1'b0, alu_a} - {1'b0, alu_b};
                alu_y = s[WIDTH-1:0]; alu_carry = s[WIDTH];
                alu_ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (s[WIDTH-1] != alu_a[WIDTH-1]);
            end
            5'd2:  alu_y = alu_a & alu_b;
            5'd3:  alu_y = alu_a | alu_b;
            5'd4:  alu_y = ~(alu_a & alu_b);
            5'd5:  alu_y = alu_a ^ alu_b;
            5'd7:  alu_y = {alu_a[WIDTH-2:0], 1'b0};
            5'd8:  alu_y = {1'b0, alu_a[WIDTH-1:1]};
            5'd9:  alu_y = ~alu_a;
            5'd10: alu_y = alu_b;
            default: begin
                alu_y = alu_a | alu_b | 16'h0001; alu_carry = 1'b1; alu_ovf = 1'b1;
            end
        endcase
    end

    // Reference: expected response computed with integer arithmetic from the opcode rules.
    function automatic void ref_op(input logic [15:0] a, input logic [15:0] b, input logic [4:0] op,
                                   output logic [15:0] y, output logic [2:0] f);
        int ia, ib, io, sa, sb, sr, r;
        logic c, v;
        ia = int'(a); ib = int'(b); io = int'(op);
        sa = (ia >= 32768) ? ia - 65536 : ia;
        sb = (ib >= 32768) ? ib - 65536 : ib;
        c = 1'b0; v = 1'b0; r = 0;
        if (io == 6 || io > 10) begin
            y = 16'h0000; f = 3'b100;
            return;
        end
        case (io)
            0: begin r = ia + ib; c = (r > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            1: begin r = ia - ib; c = (ia < ib);   sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            2: r = ia & ib;
            3: r = ia | ib;
            4: r = 65535 - (ia & ib);
            5: r = ia ^ ib;
            7: r = ia * 2;
            8: r = ia / 2;
            9: r = 65535 - ia;
            default: r = ib;
        endcase
        y = r[15:0];
        f = {1'b0, c, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0001; req0_op = 5'd0;
        req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step(); step(); #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b exp 0", req0_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", {rsp0_valid, rsp1_valid}); end
        checks++; if ({rsp0_y, rsp0_flags} !== 19'h0) begin errors++; $display("FAIL reset_rsp_data got %h/%b exp 0/000", rsp0_y, rsp0_flags); end
        checks++; if ({alu_a, alu_b, alu_op} !== 37'h0) begin errors++; $display("FAIL reset_alu_regs got %h %h %h exp 0", alu_a, alu_b, alu_op); end
        req0_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single_op();
        do_reset();
        req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0004; req0_op = 5'd0; rsp0_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_accept got %b exp 1", req0_ready); end
        step(); req0_valid = 1'b0; #1;
        checks++; if ({busy, rsp0_valid} !== 2'b10) begin errors++; $display("FAIL single_exec busy/valid got %b exp 10", {busy, rsp0_valid}); end
        checks++; if ({alu_a, alu_b} !== {16'h0003, 16'h0004}) begin errors++; $display("FAIL single_alu_operands got %h %h exp 0003 0004", alu_a, alu_b); end
        step(); #1;
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin errors++; $display("FAIL single_rsp_valid got %b exp 10", {rsp0_valid, rsp1_valid}); end
        checks++; if ({rsp0_y, rsp0_flags} !== {16'h0007, 3'b000}) begin errors++; $display("FAIL single_rsp_data got %h/%b exp 0007/000", rsp0_y, rsp0_flags); end
        step(); #1;
        checks++; if ({rsp0_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_done valid/busy got %b exp 00", {rsp0_valid, busy}); end
        checks++; if (rsp0_y !== 16'h0007) begin errors++; $display("FAIL single_hold_after got %h exp 0007", rsp0_y); end
    endtask

    task automatic test_contention();
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 16'd1;  req0_b = 16'd2; req0_op = 5'd0;
        req1_valid = 1'b1; req1_a = 16'd10; req1_b = 16'd3; req1_op = 5'd1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL cont_first_grant got %b exp 10", {req0_ready, req1_ready}); end
        step(); req0_valid = 1'b0;
        step(); #1;
        checks++; if ({rsp0_valid, rsp0_y} !== {1'b1, 16'd3}) begin errors++; $display("FAIL cont_rsp0 got %b/%h exp 1/0003", rsp0_valid, rsp0_y); end
        step();
        req0_valid = 1'b1; req0_a = 16'd5; req0_b = 16'd5; req0_op = 5'd2;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL cont_second_grant got %b exp 01", {req0_ready, req1_ready}); end
        step(); req1_valid = 1'b0;
        step(); #1;
        checks++; if ({rsp1_valid, rsp0_valid, rsp1_y, rsp1_flags} !== {2'b10, 16'd7, 3'b000}) begin
            errors++; $display("FAIL cont_rsp1 got %b%b/%h/%b exp 10/0007/000", rsp1_valid, rsp0_valid, rsp1_y, rsp1_flags); end
        step();
        req1_valid = 1'b1; req1_a = 16'd9; req1_b = 16'd9; req1_op = 5'd3;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL cont_third_grant got %b exp 10", {req0_ready, req1_ready}); end
        step(); req0_valid = 1'b0; req1_valid = 1'b0;
        step(); #1;
        checks++; if ({rsp0_valid, rsp0_y} !== {1'b1, 16'd5}) begin errors++; $display("FAIL cont_rsp0_again got %b/%h exp 1/0005", rsp0_valid, rsp0_y); end
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        req1_valid = 1'b1; req1_a = 16'hFF00; req1_b = 16'h0FF0; req1_op = 5'd5;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_op = 5'd0;
        rsp0_ready = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({rsp1_valid, rsp0_valid, busy, req0_ready} !== 4'b1010) begin
                errors++; $display("FAIL bp_ctrl cycle %0d got %b exp 1010", i, {rsp1_valid, rsp0_valid, busy, req0_ready}); end
            checks++; if ({rsp1_y, rsp1_flags} !== {16'hF0F0, 3'b000}) begin
                errors++; $display("FAIL bp_data cycle %0d got %h/%b exp F0F0/000", i, rsp1_y, rsp1_flags); end
            step();
        end
        rsp1_ready = 1'b1;
        step(); #1;
        checks++; if ({rsp1_valid, req0_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got %b exp 01", {rsp1_valid, req0_ready}); end
        req0_valid = 1'b0;
    endtask

    task automatic test_illegal();
        logic [4:0] ops [3];
        ops[0] = 5'd6; ops[1] = 5'd11; ops[2] = 5'd31;
        do_reset();
        rsp0_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = ops[i];
            step(); req0_valid = 1'b0;
            step(); #1;
            checks++; if ({rsp0_valid, rsp0_y, rsp0_flags} !== {1'b1, 16'h0000, 3'b100}) begin
                errors++; $display("FAIL illegal_op%0d got %b/%h/%b exp 1/0000/100", ops[i], rsp0_valid, rsp0_y, rsp0_flags); end
            step();
        end
    endtask

    task automatic test_flags();
        do_reset();
        rsp1_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0001; req1_op = 5'd0;
        step(); req1_valid = 1'b0;
        step(); #1;
        checks++; if ({rsp1_valid, rsp1_y, rsp1_flags} !== {1'b1, 16'h0000, 3'b010}) begin
            errors++; $display("FAIL flags_carry got %b/%h/%b exp 1/0000/010", rsp1_valid, rsp1_y, rsp1_flags); end
        step();
        req1_valid = 1'b1; req1_a = 16'h7FFF; req1_b = 16'h0001; req1_op = 5'd0;
        step(); req1_valid = 1'b0;
        step(); #1;
        checks++; if ({rsp1_y, rsp1_flags} !== {16'h8000, 3'b001}) begin
            errors++; $display("FAIL flags_ovf got %h/%b exp 8000/001", rsp1_y, rsp1_flags); end
        step();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 16'h0011; req1_b = 16'h0022; req1_op = 5'd3;
        step();
        req1_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; #1;
        checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin errors++; $display("FAIL midrst_after got %b exp 000", {busy, rsp0_valid, rsp1_valid}); end
        step(); #1;
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL midrst_no_rsp got %b exp 00", {rsp0_valid, rsp1_valid}); end
        req0_valid = 1'b1; req0_a = 16'h1; req0_b = 16'h1; req0_op = 5'd0;
        req1_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL midrst_prio got %b exp 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        // reset in the response cycle wins over a simultaneous handshake
        step(); step();
        req1_valid = 1'b1;
        step(); req1_valid = 1'b0;
        step(); rst = 1'b1;
        step(); rst = 1'b0; #1;
        checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin errors++; $display("FAIL rsprst_after got %b exp 000", {busy, rsp0_valid, rsp1_valid}); end
    endtask

    task automatic test_random();
        logic        pv [2];
        logic [15:0] pa [2];
        logic [15:0] pb [2];
        logic [4:0]  po [2];
        logic        prio_m, outstanding, owner_m, hs_next;
        int          age, acc_next;
        logic [15:0] exp_y;
        logic [2:0]  exp_f;
        logic        er0, er1, ev0, ev1;
        do_reset();
        pv[0] = 1'b0; pv[1] = 1'b0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0; po[0] = '0; po[1] = '0;
        prio_m = 1'b0; outstanding = 1'b0; owner_m = 1'b0; age = 0;
        exp_y = '0; exp_f = '0; hs_next = 1'b0; acc_next = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc > 0) step();
            if (hs_next) outstanding = 1'b0;
            if (acc_next >= 0) begin
                outstanding = 1'b1; age = 0; owner_m = acc_next[0];
                ref_op(pa[acc_next], pb[acc_next], po[acc_next], exp_y, exp_f);
                prio_m = ~acc_next[0];
                pv[acc_next] = 1'b0;
            end else if (outstanding) begin
                age++;
            end
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 1) == 1) begin
                    pv[p] = 1'b1; pa[p] = 16'($urandom); pb[p] = 16'($urandom);
                    po[p] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(11, 31)) : 5'($urandom_range(0, 10));
                end
            end
            req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = po[0];
            req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = po[1];
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            #1;
            er0 = !outstanding && pv[0] && (!prio_m || !pv[1]);
            er1 = !outstanding && pv[1] && ( prio_m || !pv[0]);
            ev0 = outstanding && age >= 1 && !owner_m;
            ev1 = outstanding && age >= 1 &&  owner_m;
            checks++; if ({req0_ready, req1_ready} !== {er0, er1}) begin
                errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, {req0_ready, req1_ready}, {er0, er1}); end
            checks++; if ({rsp0_valid, rsp1_valid, busy} !== {ev0, ev1, outstanding}) begin
                errors++; $display("FAIL rand_ctrl cyc %0d got %b exp %b", cyc, {rsp0_valid, rsp1_valid, busy}, {ev0, ev1, outstanding}); end
            if (ev0) begin
                checks++; if ({rsp0_y, rsp0_flags} !== {exp_y, exp_f}) begin
                    errors++; $display("FAIL rand_rsp0 cyc %0d got %h/%b exp %h/%b", cyc, rsp0_y, rsp0_flags, exp_y, exp_f); end
            end
            if (ev1) begin
                checks++; if ({rsp1_y, rsp1_flags} !== {exp_y, exp_f}) begin
                    errors++; $display("FAIL rand_rsp1 cyc %0d got %h/%b exp %h/%b", cyc, rsp1_y, rsp1_flags, exp_y, exp_f); end
            end
            acc_next = er0 ? 0 : (er1 ? 1 : -1);
            hs_next  = (ev0 && rsp0_ready) || (ev1 && rsp1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_illegal();
        test_flags();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter OPW, default 5, opcode width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports reqN_valid  input  1, reqN_ready  output  1, for N=0,1; request handshake.
REQ-006 SHALL have ports reqN_a, reqN_b  input  WIDTH, and reqN_op  input  OPW; operands and opcode.
REQ-007 SHALL have ports rspN_valid  output  1, rspN_ready  input  1; response handshake.
REQ-008 SHALL have ports rspN_y  output  WIDTH, and rspN_flags  output  3; flags = {err, carry, ovf}.
REQ-009 SHALL have ports alu_a, alu_b  output  WIDTH, and alu_op  output  OPW; drive shared ALU.
REQ-010 SHALL have ports alu_y  input  WIDTH, alu_carry  input  1, alu_ovf  input  1; combinational ALU results.
REQ-011 SHALL have port busy  output  1; high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP; IDLE->EXEC on accept; EXEC->RESP unconditionally; RESP->IDLE on response handshake.
REQ-013 SHALL assert reqN_ready combinationally only in IDLE: port N valid and (prio==N or other port not valid).
REQ-014 SHALL accept a request when reqN_valid && reqN_ready; at most one accept per cycle.
REQ-015 SHALL register a, b, op and owner id on accept; alu_a/alu_b/alu_op are those registers, stable from EXEC through RESP.
REQ-016 SHALL in EXEC capture alu_y, alu_carry, alu_ovf into the result registers.
REQ-017 SHALL treat opcodes 0-5 and 7-10 as legal; opcode 6 and 11-31 illegal: result y=0, flags=3'b100, ALU outputs ignored.
REQ-018 SHALL set err=0 for legal opcodes, carry/ovf passed through unchanged.
REQ-019 SHALL in RESP assert rspN_valid only for the owner port; other port's rsp_valid stays 0.
REQ-020 SHALL hold rspN_y and rspN_flags stable while rspN_valid=1 and rspN_ready=0 (backpressure unbounded).
REQ-021 SHALL leave rsp_y/flags holding last result after handshake; valid alone qualifies data.
REQ-022 SHALL have latency: accept at cycle T -> rsp_valid at T+2; earliest next accept T+3 if rsp_ready at T+2.
REQ-023 SHALL not accept a new request in the handshake cycle of a response (no same-cycle RESP->accept).
REQ-024 SHALL flip prio to the other port on every accept (round-robin); a lone requester is granted regardless of prio.
REQ-025 SHALL ignore rspN_ready when no response is pending for port N.
REQ-026 SHALL ignore req changes on a port while not ready; requesters hold valid/data until accepted.

Reset
REQ-027 SHALL on rst: state=IDLE, prio=0, all reqN_ready=0 and rspN_valid=0, rsp_y=0, rsp_flags=0, alu_a/alu_b/alu_op=0, busy=0.
REQ-028 SHALL discard any in-flight operation on rst (EXEC or RESP) with no response issued afterward.
REQ-029 SHALL have rst take priority over any simultaneous handshake in the same cycle.

Verification
REQ-030 Single op: req0 a=0x0003 b=0x0004 op=0, ALU model add -> rsp0_valid at T+2, y=0x0007, flags=000.
REQ-031 Contention: req0 and req1 valid same cycle after reset -> port0 first, port1 next accept at T+3; then both again -> port0 granted after port1.
REQ-032 Backpressure: rsp1_ready=0 for 5 cycles on op=5 a=0xFF00 b=0x0FF0 -> rsp1_y=0xF0F0 held, busy=1, req0_ready=0 throughout.
REQ-033 Illegal op: req0 op=6 -> rsp0_y=0x0000, flags=100; op=11 likewise.
REQ-034 Flags: op=0 a=0xFFFF b=0x0001 with ALU carry=1 -> rsp_y=0x0000, flags=010.
REQ-035 Reset mid-op: rst pulsed in EXEC -> next cycle busy=0, no rsp_valid on either port, prio=0.
